// File: rtl/char_motion_ctrl_pkg.sv
// Shared types and constants for the character motion controller.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the velocity register width and the
// helpers that derive the map movement bounds from the window/sprite geometry.
package char_motion_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WALK   = 3'd1,
    ST_CHARGE = 3'd2,
    ST_AIR    = 3'd3,
    ST_LAND   = 3'd4
  } state_e;

  // Signed velocity width: holds +(MAX_CHARGE+1) and -(MAX_CHARGE+1).
  localparam int VEL_W = 6;

  // Lowest y the sprite can rest on: bottom of the map minus sprite height.
  function automatic int calc_ground_y(input int map_y_offset, input int map_width_y,
                                       input int char_width_y);
    return map_y_offset + map_width_y - char_width_y;
  endfunction

  // Right-most x that keeps the whole sprite inside the map.
  function automatic int calc_x_max(input int map_x_offset, input int map_width_x,
                                    input int char_width_x);
    return map_x_offset + map_width_x - char_width_x;
  endfunction

  // Bounds for the default geometry (270/50 offset, 100x100 map, 32x32 sprite).
  localparam int GROUND_Y = calc_ground_y(50, 100, 32);   // 118
  localparam int TOP_Y    = 50;
  localparam int X_MIN    = 270;
  localparam int X_MAX    = calc_x_max(270, 100, 32);     // 338

endpackage

// File: rtl/char_motion_ctrl_frame_tick_gen.sv
// Frame update strobe: one pulse when the beam first reaches (0, V_ACTIVE).
// Latency: frame_tick is registered, high the cycle after the beam arrives.
// Backpressure: none; a beam dwelling on the position yields a single pulse.
//
// Ports: sys_clk/sys_rst_n clock and async active-low reset; x, y beam
// position; frame_tick one-cycle update strobe.
module frame_tick_gen #(
  parameter int SCREEN_WIDTH = 10,
  parameter int V_ACTIVE     = 480
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [SCREEN_WIDTH-1:0] x,
  input  logic [SCREEN_WIDTH-1:0] y,
  output logic                    frame_tick
);

  logic at_pos;
  logic at_pos_d, at_pos_q;
  logic tick_d, tick_q;

  assign at_pos = (x == '0) && (y == SCREEN_WIDTH'(V_ACTIVE));

  // Rising-edge detect on the position match so a dwelling beam fires once.
  always_comb begin
    at_pos_d = at_pos;
    tick_d   = at_pos & ~at_pos_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      at_pos_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      at_pos_q <= at_pos_d;
      tick_q   <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/char_motion_ctrl.sv
// Character motion controller: walk, charged jump, wall bounce, ceiling, landing.
// Latency: state and position update on the clock edge ending a frame_tick cycle.
// Backpressure: none; buttons are sampled only on frame_tick, ignored otherwise.
//
// Ports: sys_clk/sys_rst_n clock and async active-low reset; x, y beam
// position; btn_left/btn_right/btn_jump synchronized levels; char_x/char_y
// registered sprite top-left; state FSM state; charge jump charge level;
// frame_tick once-per-frame update strobe.
module char_motion_ctrl
  import char_motion_ctrl_pkg::*;
#(
  parameter int SCREEN_WIDTH = 10,
  parameter int MAP_X_OFFSET = 270,
  parameter int MAP_Y_OFFSET = 50,
  parameter int MAP_WIDTH_X  = 100,
  parameter int MAP_WIDTH_Y  = 100,
  parameter int CHAR_WIDTH_X = 32,
  parameter int CHAR_WIDTH_Y = 32,
  parameter int INIT_X       = 304,
  parameter int V_ACTIVE     = 480,
  parameter int WALK_STEP    = 1,
  parameter int MAX_CHARGE   = 15
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [SCREEN_WIDTH-1:0] x,
  input  logic [SCREEN_WIDTH-1:0] y,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_jump,
  output logic [SCREEN_WIDTH-1:0] char_x,
  output logic [SCREEN_WIDTH-1:0] char_y,
  output logic [2:0]              state,
  output logic [3:0]              charge,
  output logic                    frame_tick
);

  // Two spare bits so x - step or y - vy can go negative without wrapping.
  localparam int PW = SCREEN_WIDTH + 2;

  localparam int GROUND_Y_P = calc_ground_y(MAP_Y_OFFSET, MAP_WIDTH_Y, CHAR_WIDTH_Y);
  localparam int X_MAX_P    = calc_x_max(MAP_X_OFFSET, MAP_WIDTH_X, CHAR_WIDTH_X);

  localparam logic signed [PW-1:0]    X_MIN_S    = PW'(MAP_X_OFFSET);
  localparam logic signed [PW-1:0]    X_MAX_S    = PW'(X_MAX_P);
  localparam logic signed [PW-1:0]    TOP_S      = PW'(MAP_Y_OFFSET);
  localparam logic signed [PW-1:0]    GROUND_S   = PW'(GROUND_Y_P);
  localparam logic signed [PW-1:0]    STEP_S     = PW'(WALK_STEP);
  localparam logic signed [VEL_W-1:0] VX_JUMP    = VEL_W'(2 * WALK_STEP);
  localparam logic signed [VEL_W-1:0] VY_MIN     = VEL_W'(-(MAX_CHARGE + 1));
  localparam logic signed [VEL_W-1:0] VEL_ONE    = VEL_W'(1);
  localparam logic [3:0]              CHARGE_MAX = 4'(MAX_CHARGE);

  logic [SCREEN_WIDTH-1:0] char_x_d, char_x_q;
  logic [SCREEN_WIDTH-1:0] char_y_d, char_y_q;
  state_e                  state_d, state_q;
  logic [3:0]              charge_d, charge_q;
  logic signed [VEL_W-1:0] vx_d, vx_q;
  logic signed [VEL_W-1:0] vy_d, vy_q;

  logic                    tick;
  logic                    dir_left, dir_right;
  logic signed [PW-1:0]    cur_x, cur_y;
  logic signed [PW-1:0]    walk_x, air_x, air_y;
  logic signed [VEL_W-1:0] vy_dec;

  frame_tick_gen #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .V_ACTIVE     (V_ACTIVE)
  ) u_frame_tick_gen (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .x          (x),
    .y          (y),
    .frame_tick (tick)
  );

  // Opposing buttons cancel out.
  assign dir_left  = btn_left & ~btn_right;
  assign dir_right = btn_right & ~btn_left;

  assign cur_x  = {2'b00, char_x_q};
  assign cur_y  = {2'b00, char_y_q};
  assign walk_x = cur_x + (dir_right ? STEP_S : -STEP_S);
  assign air_x  = cur_x + PW'(vx_q);
  assign air_y  = cur_y - PW'(vy_q);    // upward velocity is positive
  assign vy_dec = (vy_q <= VY_MIN) ? VY_MIN : vy_q - VEL_ONE;

  always_comb begin
    char_x_d = char_x_q;
    char_y_d = char_y_q;
    state_d  = state_q;
    charge_d = charge_q;
    vx_d     = vx_q;
    vy_d     = vy_q;

    if (tick) begin
      unique case (state_q)
        ST_IDLE, ST_WALK: begin
          if (btn_jump) begin
            state_d  = ST_CHARGE;
            charge_d = '0;
          end else if (dir_left || dir_right) begin
            state_d = ST_WALK;
            if (walk_x < X_MIN_S)      char_x_d = X_MIN_S[SCREEN_WIDTH-1:0];
            else if (walk_x > X_MAX_S) char_x_d = X_MAX_S[SCREEN_WIDTH-1:0];
            else                       char_x_d = walk_x[SCREEN_WIDTH-1:0];
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_CHARGE: begin
          if (btn_jump) begin
            if (charge_q < CHARGE_MAX) charge_d = charge_q + 4'd1;
          end else begin
            // Launch only; the first position change happens next tick.
            state_d = ST_AIR;
            vy_d    = VEL_W'(charge_q) + VEL_ONE;
            if (dir_left)       vx_d = -VX_JUMP;
            else if (dir_right) vx_d = VX_JUMP;
            else                vx_d = '0;
          end
        end

        ST_AIR: begin
          // Horizontal: clamp to the violated wall and reverse direction.
          if (air_x < X_MIN_S) begin
            char_x_d = X_MIN_S[SCREEN_WIDTH-1:0];
            vx_d     = -vx_q;
          end else if (air_x > X_MAX_S) begin
            char_x_d = X_MAX_S[SCREEN_WIDTH-1:0];
            vx_d     = -vx_q;
          end else begin
            char_x_d = air_x[SCREEN_WIDTH-1:0];
          end

          // Vertical: ceiling kills upward speed, ground ends the jump.
          if (air_y < TOP_S) begin
            char_y_d = TOP_S[SCREEN_WIDTH-1:0];
            vy_d     = '0;
          end else if (air_y >= GROUND_S) begin
            char_y_d = GROUND_S[SCREEN_WIDTH-1:0];
            vx_d     = '0;
            vy_d     = '0;
            state_d  = ST_LAND;
          end else begin
            char_y_d = air_y[SCREEN_WIDTH-1:0];
            vy_d     = vy_dec;
          end
        end

        ST_LAND: begin
          state_d  = ST_IDLE;
          charge_d = '0;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      char_x_q <= SCREEN_WIDTH'(INIT_X);
      char_y_q <= SCREEN_WIDTH'(GROUND_Y_P);
      state_q  <= ST_IDLE;
      charge_q <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
    end else begin
      char_x_q <= char_x_d;
      char_y_q <= char_y_d;
      state_q  <= state_d;
      charge_q <= charge_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
    end
  end

  assign char_x     = char_x_q;
  assign char_y     = char_y_q;
  assign state      = state_q;
  assign charge     = charge_q;
  assign frame_tick = tick;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Bench for char_motion_ctrl: random frames against a behavioural model,
// plus hand-computed trajectories for reset, jump, ceiling, wall and walk.
module tb_char_motion_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [9:0] x, y;
  logic       btn_left, btn_right, btn_jump;
  logic [9:0] char_x, char_y;
  logic [2:0] state;
  logic [3:0] charge;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;

  char_motion_ctrl dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .x          (x),
    .y          (y),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .char_x     (char_x),
    .char_y     (char_y),
    .state      (state),
    .charge     (charge),
    .frame_tick (frame_tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // States as plain numbers: 0 idle, 1 walk, 2 charge, 3 air, 4 land.
  int m_x = 304, m_y = 118, m_st = 0, m_ch = 0, m_vx = 0, m_vy = 0;
  bit m_tick = 0, m_prev_at = 0;

  task automatic model_step(input bit bl, input bit br, input bit bj);
    bit l, r;
    int nx, ny;
    l = bl && !br;
    r = br && !bl;
    case (m_st)
      0, 1: begin
        if (bj) begin
          m_st = 2; m_ch = 0;
        end else if (l || r) begin
          m_st = 1;
          m_x  = m_x + (r ? 1 : -1);
          if (m_x < 270) m_x = 270;
          if (m_x > 338) m_x = 338;
        end else begin
          m_st = 0;
        end
      end
      2: begin
        if (bj) begin
          if (m_ch < 15) m_ch = m_ch + 1;
        end else begin
          m_st = 3;
          m_vy = m_ch + 1;
          m_vx = l ? -2 : (r ? 2 : 0);
        end
      end
      3: begin
        nx = m_x + m_vx;
        ny = m_y - m_vy;
        if (nx < 270)      begin m_x = 270; m_vx = -m_vx; end
        else if (nx > 338) begin m_x = 338; m_vx = -m_vx; end
        else               m_x = nx;
        if (ny < 50) begin
          m_y = 50; m_vy = 0;
        end else if (ny >= 118) begin
          m_y = 118; m_vx = 0; m_vy = 0; m_st = 4;
        end else begin
          m_y = ny;
          m_vy = (m_vy - 1 < -16) ? -16 : m_vy - 1;
        end
      end
      4: begin
        m_st = 0; m_ch = 0;
      end
      default: m_st = 0;
    endcase
  endtask

  always @(posedge sys_clk or negedge sys_rst_n) begin
    bit at;
    if (!sys_rst_n) begin
      m_x = 304; m_y = 118; m_st = 0; m_ch = 0; m_vx = 0; m_vy = 0;
      m_tick = 0; m_prev_at = 0;
    end else begin
      if (m_tick) model_step(btn_left, btn_right, btn_jump);
      at = (x == 10'd0) && (y == 10'd480);
      m_tick = at && !m_prev_at;
      m_prev_at = at;
    end
  end

  // Every cycle: DUT outputs must match the model.
  always @(negedge sys_clk) begin
    chk("cmp_tick",   int'(frame_tick), int'(m_tick));
    chk("cmp_char_x", int'(char_x), m_x);
    chk("cmp_char_y", int'(char_y), m_y);
    chk("cmp_state",  int'(state),  m_st);
    chk("cmp_charge", int'(charge), m_ch);
  end

  // ---------------- stimulus ----------------
  // One frame: active video with random beam and button noise, then the
  // beam parks on the tick position (random dwell) with the chosen buttons.
  task automatic frame(input bit l, input bit r, input bit j);
    int dwell;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #2;
      x = 10'($urandom_range(1, 639));
      y = 10'($urandom_range(0, 479));
      btn_left  = 1'($urandom);
      btn_right = 1'($urandom);
      btn_jump  = 1'($urandom);
    end
    @(posedge sys_clk); #2;
    btn_left = l; btn_right = r; btn_jump = j;
    x = 10'd0; y = 10'd480;
    dwell = $urandom_range(1, 4);
    repeat (dwell) begin @(posedge sys_clk); #2; end
    x = 10'd5; y = 10'd481;
    repeat (2) begin @(posedge sys_clk); #2; end
  endtask

  task automatic frames(input int n, input bit l, input bit r, input bit j);
    for (int i = 0; i < n; i++) frame(l, r, j);
  endtask

  int exp_short[7] = '{115, 113, 112, 112, 113, 115, 118};
  int exp_ceil[5]  = '{102, 87, 73, 60, 50};
  int exp_walk[5]  = '{271, 270, 270, 270, 270};

  initial begin
    int guard;
    sys_rst_n = 1'b0;
    x = 10'd5; y = 10'd481;
    btn_left = 0; btn_right = 0; btn_jump = 0;
    repeat (3) @(posedge sys_clk);
    #2;
    chk("rst_x", int'(char_x), 304);
    chk("rst_y", int'(char_y), 118);
    chk("rst_tick", int'(frame_tick), 0);
    sys_rst_n = 1'b1;

    // Reset then two quiet frames.
    frames(2, 0, 0, 0);
    chk("idle_x", int'(char_x), 304);
    chk("idle_y", int'(char_y), 118);
    chk("idle_state", int'(state), 0);
    chk("idle_charge", int'(charge), 0);

    // Both directions cancel.
    for (int i = 0; i < 5; i++) begin
      frame(1, 1, 0);
      chk("lr_x", int'(char_x), 304);
      chk("lr_state", int'(state), 0);
    end

    // Short jump: three charge ticks, release.
    frames(3, 0, 0, 1);
    chk("short_charge", int'(charge), 2);
    frame(0, 0, 0);
    chk("short_release_state", int'(state), 3);
    chk("short_release_y", int'(char_y), 118);
    for (int i = 0; i < 7; i++) begin
      frame(0, 0, 0);
      chk("short_y", int'(char_y), exp_short[i]);
    end
    chk("short_land", int'(state), 4);
    frame(0, 0, 0);
    chk("short_idle", int'(state), 0);
    chk("short_charge_clr", int'(charge), 0);

    // Ceiling: full charge.
    frames(20, 0, 0, 1);
    chk("ceil_charge", int'(charge), 15);
    frame(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      frame(0, 0, 0);
      chk("ceil_y", int'(char_y), exp_ceil[i]);
    end
    guard = 0;
    while (m_st != 0 && guard < 40) begin frame(0, 0, 0); guard++; end
    chk("ceil_back_ground", int'(char_y), 118);
    chk("ceil_back_idle", int'(state), 0);

    // Wall bounce from 336.
    guard = 0;
    while (m_x != 336 && guard < 60) begin frame(0, 1, 0); guard++; end
    chk("wall_start_x", int'(char_x), 336);
    frame(0, 0, 1);
    frame(0, 1, 0);
    frame(0, 0, 0);
    chk("wall_x0", int'(char_x), 338);
    frame(1, 0, 1);    // buttons ignored in the air
    chk("wall_x1", int'(char_x), 338);
    frame(0, 0, 0);
    chk("wall_x2", int'(char_x), 336);
    chk("wall_land", int'(state), 4);
    frame(0, 0, 0);

    // Walk left into the left bound.
    guard = 0;
    while (m_x != 272 && guard < 100) begin frame(1, 0, 0); guard++; end
    chk("walk_start_x", int'(char_x), 272);
    for (int i = 0; i < 5; i++) begin
      frame(1, 0, 0);
      chk("walk_x", int'(char_x), exp_walk[i]);
    end

    // Button noise without a tick changes nothing.
    for (int i = 0; i < 30; i++) begin
      @(posedge sys_clk); #2;
      x = 10'($urandom_range(1, 639));
      y = 10'($urandom_range(0, 479));
      btn_left = 1'($urandom); btn_right = 1'($urandom); btn_jump = 1'($urandom);
    end
    chk("notick_x", int'(char_x), 270);
    chk("notick_state", int'(state), 1);

    // Random frames.
    for (int i = 0; i < 150; i++)
      frame(1'($urandom), 1'($urandom), ($urandom_range(0, 9) < 3));

    // Reset in the middle of a jump.
    frame(0, 0, 0);
    guard = 0;
    while (m_st != 0 && guard < 60) begin frame(0, 0, 0); guard++; end
    frames(5, 0, 0, 1);
    frame(1, 0, 0);
    frames(2, 0, 0, 0);
    chk("air_before_rst", int'(state), 3);
    sys_rst_n = 1'b0;
    #1;
    chk("midair_rst_y", int'(char_y), 118);
    chk("midair_rst_state", int'(state), 0);
    chk("midair_rst_x", int'(char_x), 304);
    chk("midair_rst_charge", int'(charge), 0);
    repeat (2) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    frames(2, 0, 0, 0);
    chk("post_rst_y", int'(char_y), 118);
    chk("post_rst_state", int'(state), 0);

    @(posedge sys_clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
